// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM host-port arbiter.
// FSM state and operation encodings, pointer width, and a modulo helper
// for the round-robin search.
package sdram_arb_pkg;

  // Largest supported requester count. The pointer and index are sized for
  // it so that every configuration from 2 to 8 ports shares one width.
  localparam int NUM_PORTS_MAX = 8;
  localparam int PTR_WIDTH     = $clog2(NUM_PORTS_MAX);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACC  = 3'd2,
    WAIT_DONE = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

  // Port number reached by stepping 'offset' places from 'base', wrapping
  // at num_ports.
  function automatic logic [PTR_WIDTH-1:0] wrap_port(
    input logic [PTR_WIDTH-1:0] base,
    input int                   offset,
    input int                   num_ports
  );
    return PTR_WIDTH'((int'(base) + offset) % num_ports);
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: host-side bus of the SDRAM controller.
// master = the arbiter driving strobes/address/data, slave = the controller.
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);

  logic                  mem_wr_enable;
  logic                  mem_rd_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_ready;

  modport master (
    output mem_wr_enable, mem_rd_enable, mem_addr, mem_wdata,
    input  mem_busy, mem_rd_data, mem_rd_ready
  );

  modport slave (
    input  mem_wr_enable, mem_rd_enable, mem_addr, mem_wdata,
    output mem_busy, mem_rd_data, mem_rd_ready
  );

endinterface

// File: rtl/sdram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder.
// Default: search starts at ptr_i and wraps; first active request wins.
// With SDRAM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 highest,
// and the pointer input does not exist.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  input  logic [PTR_WIDTH-1:0] ptr_i,
`endif
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [PTR_WIDTH-1:0] grant_idx_o,
  output logic                 grant_valid_o
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN

  // Scan from the top so the lowest-numbered active port is left standing.
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_idx_o   = PTR_WIDTH'(i);
        grant_valid_o = 1'b1;
      end
    end
  end

`else

  logic [NUM_PORTS_MAX-1:0] req_ext;
  logic [PTR_WIDTH-1:0]     cand;

  // Widen so a full-width candidate index never selects past the vector.
  assign req_ext = NUM_PORTS_MAX'(req_i);

  // Walk the ports starting at the pointer; the first active one wins.
  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand = wrap_port(ptr_i, off, NUM_PORTS);
      if (!grant_valid_o && req_ext[cand]) begin
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
  end

`endif

  // Expand the winning index into a one-hot grant.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_o[i] = grant_valid_o && (grant_idx_o == PTR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller host port between
// NUM_PORTS requesters, one transaction outstanding at a time.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN selects strict fixed
// priority (port 0 highest) instead of round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_wr_i,
  input  logic [NUM_PORTS-1:0]             req_rd_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_PORTS-1:0]             req_ack_o,
  output logic [NUM_PORTS-1:0]             req_rvalid_o,
  output logic [DATA_WIDTH-1:0]            req_rdata_o,
  sdram_port_arbiter_if.master             mem
);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [NUM_PORTS-1:0]  ack_q;
  logic [NUM_PORTS-1:0]  rvalid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [NUM_PORTS-1:0]  arb_req;
  logic [NUM_PORTS-1:0]  arb_grant;
  logic [PTR_WIDTH-1:0]  arb_idx;
  logic                  arb_valid;
  logic                  arb_go;
  logic                  rd_capture;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign arb_req = req_wr_i | req_rd_i;

`ifndef SDRAM_ARB_FIXED_PRIO_EN
  // First port searched in the next round: one past the last winner,
  // so the winner drops to lowest priority. Port 0 is searched first
  // after reset.
  logic [PTR_WIDTH-1:0] ptr_q;

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (arb_go) begin
      ptr_q <= wrap_port(arb_idx, 1, NUM_PORTS);
    end
  end
`endif

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .req_i         (arb_req),
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    .ptr_i         (ptr_q),
`endif
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  // Arbitrate only when idle and the controller can take a command.
  assign arb_go     = (state_q == IDLE) && !mem.mem_busy && arb_valid;
  assign rd_capture = (state_q == WAIT_DONE) && (op_q == OP_RD) && mem.mem_rd_ready;

  // Pick the winner's address and write data from the packed buses.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arb_go)                 state_d = ISSUE;
      ISSUE:                                 state_d = WAIT_ACC;
      WAIT_ACC:  if (mem.mem_busy)           state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (op_q == OP_WR) begin
          if (!mem.mem_busy)                 state_d = IDLE;
        end else if (mem.mem_rd_ready) begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (!mem.mem_busy)          state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // FSM outputs: the strobe is high for the single ISSUE cycle.
  always_comb begin
    mem.mem_wr_enable = (state_q == ISSUE) && (op_q == OP_WR);
    mem.mem_rd_enable = (state_q == ISSUE) && (op_q == OP_RD);
  end

  // Grant/transaction registers, ack pulse, and read-data return.
  // Write wins when a port asserts both; its read competes next round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      op_q     <= OP_WR;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      if (arb_go) begin
        grant_q <= arb_grant;
        op_q    <= |(req_wr_i & arb_grant) ? OP_WR : OP_RD;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        ack_q   <= arb_grant;
      end
      if (rd_capture) begin
        rdata_q  <= mem.mem_rd_data;
        rvalid_q <= grant_q;
      end
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign req_ack_o     = ack_q;
  assign req_rvalid_o  = rvalid_q;
  assign req_rdata_o   = rdata_q;

endmodule
